fb_rect_scan: RTL and testbench

Rectangle scan generator that sits directly upstream of `fb_addr`. On a start command it latches a framebuffer rectangle and emits one (x, y) coordinate per accepted beat, raster order, over a valid/ready handshake. Used by fill/clear/blit engines to drive the coordinate-to-address stage and the SRAM write path, with per-line and per-rectangle markers.

---
 rtl/fb_rect_scan.sv | 119 +++++++++++
 tb/tb_fb_rect_scan.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_scan.sv
// Rectangle scan generator: latches a clamped framebuffer rectangle on start and
// emits its (x, y) coordinates in raster order, one per accepted valid/ready beat.
module fb_rect_scan #(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int FB_X_BITS = $clog2(FB_WIDTH),
  parameter int FB_Y_BITS = $clog2(FB_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [FB_X_BITS-1:0] x0,
  input  logic [FB_X_BITS-1:0] x1,
  input  logic [FB_Y_BITS-1:0] y0,
  input  logic [FB_Y_BITS-1:0] y1,
  output logic                 busy,
  output logic                 valid,
  input  logic                 ready,
  output logic [FB_X_BITS-1:0] x,
  output logic [FB_Y_BITS-1:0] y,
  output logic                 line_last,
  output logic                 frame_last,
  output logic                 done
);

  // Handshake: a beat transfers on any rising edge where valid && ready. Once
  // valid is raised, x/y/line_last/frame_last hold until that transfer happens;
  // ready is a don't-care while valid is low.

  localparam logic [FB_X_BITS-1:0] X_MAX = FB_X_BITS'(FB_WIDTH - 1);
  localparam logic [FB_Y_BITS-1:0] Y_MAX = FB_Y_BITS'(FB_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [FB_X_BITS-1:0] x0_q;
  logic [FB_X_BITS-1:0] x1_q;
  logic [FB_Y_BITS-1:0] y1_q;
  logic [FB_X_BITS-1:0] x1_clamp;
  logic [FB_Y_BITS-1:0] y1_clamp;
  logic                 empty;
  logic                 xfer;

  always_comb begin
    x1_clamp = (x1 > X_MAX) ? X_MAX : x1;
    y1_clamp = (y1 > Y_MAX) ? Y_MAX : y1;
    empty    = (x0 > x1_clamp) || (y0 > y1_clamp) || (x0 > X_MAX) || (y0 > Y_MAX);
  end

  // Markers are derived from the registered coordinate, so they stall with it.
  assign line_last  = valid && (x == x1_q);
  assign frame_last = line_last && (y == y1_q);
  assign xfer       = valid && ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
      x     <= '0;
      y     <= '0;
      x0_q  <= '0;
      x1_q  <= '0;
      y1_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x0_q <= x0;
            x1_q <= x1_clamp;
            y1_q <= y1_clamp;
            if (empty) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              x     <= x0;
              y     <= y0;
              state <= SCAN;
              valid <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (xfer) begin
            if (frame_last) begin
              state <= DONE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (line_last) begin
              x <= x0_q;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_scan.sv
// Directed bench for fb_rect_scan on a 4x3 framebuffer: scoreboard of expected
// beats built from the requested rectangle, stall/poke/reset scenarios, summary.
module tb_fb_rect_scan;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int XB = 4;
  localparam int YB = 3;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [XB-1:0] x0, x1;
  logic [YB-1:0] y0, y1;
  logic          busy, valid, ready;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic          line_last, frame_last, done;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] exp_q[$];

  fb_rect_scan #(
    .FB_WIDTH (W),
    .FB_HEIGHT(H),
    .FB_X_BITS(XB),
    .FB_Y_BITS(YB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .x0        (x0),
    .x1        (x1),
    .y0        (y0),
    .y1        (y1),
    .busy      (busy),
    .valid     (valid),
    .ready     (ready),
    .x         (x),
    .y         (y),
    .line_last (line_last),
    .frame_last(frame_last),
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_ll"}, 32'(line_last), 0);
    check({tag, "_fl"}, 32'(frame_last), 0);
  endtask

  // Called at posedge+1 with the block idle. stall: ready pattern 1,0,0 repeating.
  // poke: pulse start mid-scan and during DONE with other bounds.
  // abort_at >= 0: assert reset after that many beats.
  task automatic run_scan(input int ax0, input int ax1, input int ay0, input int ay1,
                          input bit stall, input bit poke, input int abort_at);
    int         cx1, cy1, n, cyc, xfers;
    bit         empty, seen_done;
    logic [8:0] got, e;
    cx1   = (ax1 > W - 1) ? W - 1 : ax1;
    cy1   = (ay1 > H - 1) ? H - 1 : ay1;
    empty = (ax0 > cx1) || (ay0 > cy1) || (ax0 >= W) || (ay0 >= H);
    exp_q.delete();
    if (!empty)
      for (int yy = ay0; yy <= cy1; yy++)
        for (int xx = ax0; xx <= cx1; xx++)
          exp_q.push_back({4'(xx), 3'(yy), 1'(xx == cx1), 1'((xx == cx1) && (yy == cy1))});
    n = exp_q.size();

    start = 1'b1;
    x0 = 4'(ax0); x1 = 4'(ax1); y0 = 3'(ay0); y1 = 3'(ay1);
    @(posedge clk); #1;
    start = 1'b0;
    x0 = 4'($urandom_range(0, 15)); x1 = 4'($urandom_range(0, 15));
    y0 = 3'($urandom_range(0, 7));  y1 = 3'($urandom_range(0, 7));

    cyc = 0; xfers = 0; seen_done = 1'b0;
    while (cyc < 200) begin
      ready = stall ? (cyc % 3 == 0) : 1'b1;
      start = poke && (cyc == 2);
      if (start) begin
        x0 = 4'd1; x1 = 4'd1; y0 = 3'd1; y1 = 3'd1;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_valid", 32'(valid), 0);
        check("done_busy", 32'(busy), 0);
        check("done_ll", 32'(line_last), 0);
        check("done_beats_left", 32'(exp_q.size()), 0);
        if (!stall) check("done_latency", 32'(cyc), 32'(n));
        if (poke) begin
          start = 1'b1;
          x0 = 4'd0; x1 = 4'd0; y0 = 3'd0; y1 = 3'd0;
        end
        break;
      end
      if (valid) begin
        check("scan_busy", 32'(busy), 1);
        got = {x, y, line_last, frame_last};
        e = (exp_q.size() > 0) ? exp_q[0] : 9'bx;
        check("beat", 32'(got), 32'(e));
        if (ready) begin
          xfers++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (abort_at >= 0 && xfers == abort_at) begin
          #1 reset_n = 1'b0;
          #1;
          check_all_zero("rst_async");
          @(posedge clk); #1;
          check("rst_no_done", 32'(done), 0);
          check("rst_no_valid", 32'(valid), 0);
          reset_n = 1'b1;
          exp_q.delete();
          ready = 1'b1;
          return;
        end
      end else begin
        check("no_bubble_valid", 32'(valid), 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", 32'(seen_done), 1);
    check("xfer_count", 32'(xfers), 32'(n));
    @(posedge clk); #1;
    start = 1'b0;
    check("post_done", 32'(done), 0);
    check("post_valid", 32'(valid), 0);
    check("post_busy", 32'(busy), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    ready   = 1'b1;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle");

    run_scan(0, 3, 0, 2, 1'b0, 1'b0, -1);   // full frame, ready high
    run_scan(1, 2, 1, 2, 1'b1, 1'b0, -1);   // stalled sub-rectangle
    run_scan(2, 2, 1, 1, 1'b0, 1'b0, -1);   // single pixel
    run_scan(3, 1, 0, 2, 1'b0, 1'b0, -1);   // empty: x0 > x1
    run_scan(0, 3, 2, 0, 1'b0, 1'b0, -1);   // empty: y0 > y1
    run_scan(5, 9, 0, 1, 1'b0, 1'b0, -1);   // empty: x0 off the framebuffer
    run_scan(0, 9, 0, 7, 1'b0, 1'b0, -1);   // clamped to full frame
    run_scan(0, 3, 0, 2, 1'b0, 1'b1, -1);   // start pokes in SCAN and DONE
    run_scan(0, 3, 0, 2, 1'b0, 1'b0, 5);    // reset mid-scan
    run_scan(0, 3, 0, 2, 1'b0, 1'b0, -1);   // clean scan after reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "bench timeout");
  end

endmodule
